// File: rtl/bidi_message_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bidi_message_queue_pkg                                     |
// | Brief   : Register map, SRAM window base and client FSM state enum   |
// |           shared by the queue client and the queue's memory model.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package bidi_message_queue_pkg;

  // Word offsets of the queue pointer registers.
  localparam int unsigned MQ_IN_RD  = 0;
  localparam int unsigned MQ_IN_WR  = 1;
  localparam int unsigned MQ_OUT_RD = 2;
  localparam int unsigned MQ_OUT_WR = 3;

  // Word address of the first ring slot; outbound ring follows the inbound one.
  localparam int unsigned MQ_SRAM_BASE = 'h400;

  typedef enum logic [3:0] {
    MQC_IDLE         = 4'd0,
    MQC_IN_POLL      = 4'd1,
    MQC_IN_POLL_RSP  = 4'd2,
    MQC_IN_RD        = 4'd3,
    MQC_IN_RD_RSP    = 4'd4,
    MQC_IN_WB        = 4'd5,
    MQC_OUT_POLL     = 4'd6,
    MQC_OUT_POLL_RSP = 4'd7,
    MQC_OUT_WR       = 4'd8,
    MQC_OUT_WB       = 4'd9
  } mq_client_state_e;

endpackage
`default_nettype wire

// File: rtl/bidi_message_queue_client.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bidi_message_queue_client                                  |
// | Brief   : Bus-master engine draining the inbound ring onto an rx     |
// |           stream and filling the outbound ring from a tx stream.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bidi_message_queue_client
  import bidi_message_queue_pkg::*;
#(
  parameter int unsigned QUEUE_ADDR_BITS = 10,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned POLL_INTERVAL   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data,
  output logic [31:0]           rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [31:0]           tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready
);

  localparam int unsigned PTR_W    = QUEUE_ADDR_BITS - 1;
  localparam int unsigned QUEUE_SZ = 1 << PTR_W;
  localparam int unsigned TMR_W    = $clog2(POLL_INTERVAL + 1);

  localparam logic [PTR_W-1:0]      PTR_ONE       = PTR_W'(1);
  localparam logic [TMR_W-1:0]      TMR_ONE       = TMR_W'(1);
  localparam logic [TMR_W-1:0]      TMR_RELOAD    = TMR_W'(POLL_INTERVAL);
  localparam logic [ADDR_WIDTH-1:0] IN_RING_BASE  = ADDR_WIDTH'(MQ_SRAM_BASE);
  localparam logic [ADDR_WIDTH-1:0] OUT_RING_BASE = ADDR_WIDTH'(MQ_SRAM_BASE + QUEUE_SZ);

  mq_client_state_e state_q, state_d;
  logic [PTR_W-1:0] in_rd_q, in_rd_d;
  logic [PTR_W-1:0] out_wr_q, out_wr_d;
  logic [TMR_W-1:0] in_tmr_q, in_tmr_d;
  logic [TMR_W-1:0] out_tmr_q, out_tmr_d;
  logic             rx_valid_q, rx_valid_d;
  logic [31:0]      rx_data_q, rx_data_d;
  logic             last_out_q, last_out_d;

  logic [PTR_W-1:0] remote_ptr;
  logic [PTR_W-1:0] in_rd_inc;
  logic [PTR_W-1:0] out_wr_inc;
  logic             in_elig;
  logic             out_elig;

  // Remote pointers are masked to ring width; shadows advance modulo QUEUE_SZ.
  assign remote_ptr = mem_read_data[PTR_W-1:0];
  assign in_rd_inc  = in_rd_q + PTR_ONE;
  assign out_wr_inc = out_wr_q + PTR_ONE;
  assign in_elig    = (in_tmr_q == '0) && !rx_valid_q;
  assign out_elig   = tx_valid && (out_tmr_q == '0);

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

  // State and shadow registers; reset aborts any sequence without write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MQC_IDLE;
      in_rd_q    <= '0;
      out_wr_q   <= '0;
      in_tmr_q   <= '0;
      out_tmr_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      last_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_rd_q    <= in_rd_d;
      out_wr_q   <= out_wr_d;
      in_tmr_q   <= in_tmr_d;
      out_tmr_q  <= out_tmr_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      last_out_q <= last_out_d;
    end
  end

  // Next-state, timer, RX holding register and bus strobe decode.
  always_comb begin
    state_d        = state_q;
    in_rd_d        = in_rd_q;
    out_wr_d       = out_wr_q;
    in_tmr_d       = (in_tmr_q != '0) ? in_tmr_q - TMR_ONE : in_tmr_q;
    out_tmr_d      = (out_tmr_q != '0) ? out_tmr_q - TMR_ONE : out_tmr_q;
    rx_valid_d     = rx_valid_q;
    rx_data_d      = rx_data_q;
    last_out_d     = last_out_q;
    mem_addr       = '0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_write_data = '0;
    tx_ready       = 1'b0;

    // A new word is only loaded when the holder is empty, so no load/drain clash.
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      MQC_IDLE: begin
        if (enable) begin
          // Round-robin: on a tie the direction served last time yields.
          if (in_elig && (!out_elig || last_out_q)) begin
            state_d    = MQC_IN_POLL;
            last_out_d = 1'b0;
          end else if (out_elig) begin
            state_d    = MQC_OUT_POLL;
            last_out_d = 1'b1;
          end
        end
      end

      MQC_IN_POLL: begin
        mem_read_en = 1'b1;
        mem_addr    = ADDR_WIDTH'(MQ_IN_WR);
        state_d     = MQC_IN_POLL_RSP;
      end

      MQC_IN_POLL_RSP: begin
        if (remote_ptr == in_rd_q) begin
          in_tmr_d = TMR_RELOAD;
          state_d  = MQC_IDLE;
        end else begin
          state_d  = MQC_IN_RD;
        end
      end

      MQC_IN_RD: begin
        mem_read_en = 1'b1;
        mem_addr    = IN_RING_BASE + ADDR_WIDTH'(in_rd_q);
        state_d     = MQC_IN_RD_RSP;
      end

      MQC_IN_RD_RSP: begin
        rx_valid_d = 1'b1;
        rx_data_d  = mem_read_data;
        state_d    = MQC_IN_WB;
      end

      MQC_IN_WB: begin
        mem_write_en   = 1'b1;
        mem_addr       = ADDR_WIDTH'(MQ_IN_RD);
        mem_write_data = 32'(in_rd_inc);
        in_rd_d        = in_rd_inc;
        state_d        = MQC_IDLE;
      end

      MQC_OUT_POLL: begin
        mem_read_en = 1'b1;
        mem_addr    = ADDR_WIDTH'(MQ_OUT_RD);
        state_d     = MQC_OUT_POLL_RSP;
      end

      MQC_OUT_POLL_RSP: begin
        // One slot stays unused so full and empty remain distinguishable.
        if (out_wr_inc == remote_ptr) begin
          out_tmr_d = TMR_RELOAD;
          state_d   = MQC_IDLE;
        end else begin
          state_d   = MQC_OUT_WR;
        end
      end

      MQC_OUT_WR: begin
        mem_write_en   = 1'b1;
        mem_addr       = OUT_RING_BASE + ADDR_WIDTH'(out_wr_q);
        mem_write_data = tx_data;
        tx_ready       = 1'b1;
        state_d        = MQC_OUT_WB;
      end

      MQC_OUT_WB: begin
        mem_write_en   = 1'b1;
        mem_addr       = ADDR_WIDTH'(MQ_OUT_WR);
        mem_write_data = 32'(out_wr_inc);
        out_wr_d       = out_wr_inc;
        state_d        = MQC_IDLE;
      end

      default: begin
        state_d = MQC_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bidi_message_queue_client.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_bidi_message_queue_client                               |
// | Brief   : Scoreboard bench with a queue-memory model and host tasks. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_bidi_message_queue_client;

  localparam int QAB      = 10;
  localparam int AW       = 32;
  localparam int PI       = 16;
  localparam int QSZ      = 1 << (QAB - 1);
  localparam int IN_BASE  = 'h400;
  localparam int OUT_BASE = 'h400 + QSZ;
  localparam logic [31:0] JUNK = 32'hFFFF_FE00;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_read_en;
  logic          mem_write_en;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;
  logic [31:0]   rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [31:0]   tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;

  always #5 clk = ~clk;

  bidi_message_queue_client #(
    .QUEUE_ADDR_BITS(QAB),
    .ADDR_WIDTH     (AW),
    .POLL_INTERVAL  (PI)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .mem_addr      (mem_addr),
    .mem_read_en   (mem_read_en),
    .mem_write_en  (mem_write_en),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready)
  );

  // Queue memory: DUT port plus a host write port.
  logic [31:0] mem [0:2047];
  logic        host_we = 1'b0;
  logic [10:0] host_addr = '0;
  logic [31:0] host_data = '0;

  always @(posedge clk) begin
    if (mem_read_en)  mem_read_data <= mem[mem_addr[10:0]];
    if (mem_write_en) mem[mem_addr[10:0]] <= mem_write_data;
    if (host_we)      mem[host_addr] <= host_data;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [31:0] exp_rx[$];
  logic [31:0] exp_in_wb[$];
  logic [31:0] exp_out_wb[$];
  logic [63:0] exp_ring[$];

  int cyc = 0, in_polls = 0, out_polls = 0, in_ring_reads = 0, ring_writes = 0;
  int tx_pulses = 0, strobe_clash = 0, last_in_poll = 0, last_out_poll = 0;
  int win_out_polls = 0;
  bit measure_gaps = 0;
  logic prev_rxv = 1'b0;

  // Bus and stream monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_rxv = 1'b0;
    end else begin
      if (mem_read_en && mem_write_en) strobe_clash++;
      if (mem_read_en && mem_addr == 1) begin
        in_polls++;
        last_in_poll = cyc;
      end
      if (mem_read_en && mem_addr == 2) begin
        out_polls++;
        if (measure_gaps) begin
          win_out_polls++;
          if (last_out_poll != 0)
            check_val("repoll_gap_in_range",
                      ((cyc - last_out_poll) >= PI) && ((cyc - last_out_poll) <= PI + 8), 1);
        end
        last_out_poll = cyc;
      end
      if (mem_read_en && mem_addr >= IN_BASE && mem_addr < IN_BASE + QSZ) in_ring_reads++;
      if (mem_write_en) begin
        if (mem_addr == 0) begin
          if (exp_in_wb.size() == 0) check_val("unexpected_in_wb", 1, 0);
          else check_val("in_wb_ptr", mem_write_data, exp_in_wb.pop_front());
        end else if (mem_addr == 3) begin
          check_val("out_wb_latency", cyc - last_out_poll, 3);
          if (exp_out_wb.size() == 0) check_val("unexpected_out_wb", 1, 0);
          else check_val("out_wb_ptr", mem_write_data, exp_out_wb.pop_front());
        end else if (mem_addr >= OUT_BASE && mem_addr < OUT_BASE + QSZ) begin
          ring_writes++;
          if (exp_ring.size() == 0) check_val("unexpected_ring_write", 1, 0);
          else check_val("out_ring_addr_data", {mem_addr, mem_write_data}, exp_ring.pop_front());
        end else begin
          check_val("stray_write_addr", mem_addr, 32'hFFFF_FFFF);
        end
      end
      if (tx_ready) tx_pulses++;
      if (rx_valid && !prev_rxv) check_val("rx_latency", cyc - last_in_poll, 4);
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() == 0) check_val("unexpected_rx", 1, 0);
        else check_val("rx_data", rx_data, exp_rx.pop_front());
      end
      prev_rxv = rx_valid;
    end
  end

  int tb_in_wr = 0;
  int tb_out_wr = 0;
  int words_sent = 0;

  task automatic host_write(input int addr, input logic [31:0] data);
    host_we   = 1'b1;
    host_addr = addr[10:0];
    host_data = data;
    @(posedge clk); #1;
    host_we   = 1'b0;
  endtask

  task automatic push_in(input logic [31:0] data);
    int i;
    for (i = 0; i < 3000 && ((tb_in_wr + 1) % QSZ) == int'(mem[0][8:0]); i++) begin
      @(posedge clk); #1;
    end
    if (i >= 3000) check_val("host_ring_full_timeout", 1, 0);
    host_write(IN_BASE + tb_in_wr, data);
    tb_in_wr = (tb_in_wr + 1) % QSZ;
    exp_rx.push_back(data);
    exp_in_wb.push_back(tb_in_wr);
    host_write(1, JUNK | 32'(tb_in_wr));
  endtask

  task automatic send_tx(input logic [31:0] data);
    bit got = 0;
    exp_ring.push_back({32'(OUT_BASE + tb_out_wr), data});
    tb_out_wr = (tb_out_wr + 1) % QSZ;
    exp_out_wb.push_back(tb_out_wr);
    words_sent++;
    tx_data  = data;
    tx_valid = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (tx_ready) got = 1;
    end
    if (!got) check_val("tx_handshake_timeout", 1, 0);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int i;
    for (i = 0; i < limit && (exp_rx.size() + exp_in_wb.size() + exp_ring.size()
                              + exp_out_wb.size()) != 0; i++) @(negedge clk);
    if (i >= limit) check_val("drain_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_ring_read();
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (mem_read_en && mem_addr >= IN_BASE && mem_addr < IN_BASE + QSZ) seen = 1;
    end
    if (!seen) check_val("ring_read_timeout", 1, 0);
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_val({pfx, "_read_en"},  mem_read_en, 0);
    check_val({pfx, "_write_en"}, mem_write_en, 0);
    check_val({pfx, "_addr"},     mem_addr, 0);
    check_val({pfx, "_wdata"},    mem_write_data, 0);
    check_val({pfx, "_rx_valid"}, rx_valid, 0);
    check_val({pfx, "_rx_data"},  rx_data, 0);
    check_val({pfx, "_tx_ready"}, tx_ready, 0);
  endtask

  initial begin
    int base, pol;
    @(posedge clk); #1;
    host_write(0, 32'h0);
    host_write(1, JUNK);
    host_write(2, JUNK);
    host_write(3, 32'h0);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1; enable = 1'b1; rx_ready = 1'b1;

    // Inbound word, aborted by reset during the data response, then redelivered.
    push_in(32'hDEADBEEF);
    wait_ring_read();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    check_val("abort_wb_pending", exp_in_wb.size(), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_drain(500);

    // Outbound word into an empty ring.
    send_tx(32'h12345678);
    wait_drain(500);

    // Fill to out_wr=4, then hold the ring full with outbound_rd_ptr=5.
    send_tx(32'hF00D0001);
    send_tx(32'hF00D0002);
    send_tx(32'hF00D0003);
    wait_drain(500);
    host_write(2, JUNK | 32'd5);
    base = ring_writes;
    last_out_poll = 0;
    win_out_polls = 0;
    measure_gaps = 1;
    fork
      send_tx(32'hF00D0004);
    join_none
    repeat (80) @(negedge clk);
    check_val("full_no_ring_write", ring_writes - base, 0);
    check_val("full_repolls_ge3", win_out_polls >= 3, 1);
    @(posedge clk); #1;
    host_write(2, JUNK | 32'd6);
    wait fork;
    measure_gaps = 0;
    wait_drain(500);
    host_write(2, JUNK | 32'd5);

    // RX stall with two inbound words pending; outbound keeps flowing.
    rx_ready = 1'b0;
    base = in_ring_reads;
    push_in(32'hAAAA0001);
    push_in(32'hAAAA0002);
    for (int i = 0; i < 300 && !rx_valid; i++) @(negedge clk);
    @(posedge clk); #1;
    send_tx(32'hC0DE0001);
    send_tx(32'hC0DE0002);
    repeat (30) @(negedge clk);
    check_val("stall_rx_valid", rx_valid, 1);
    check_val("stall_rx_data", rx_data, 32'hAAAA0001);
    check_val("stall_no_prefetch", in_ring_reads - base, 1);
    check_val("stall_out_done", exp_out_wb.size(), 0);
    @(posedge clk); #1;
    rx_ready = 1'b1;
    wait_drain(500);
    check_val("stall_second_fetch", in_ring_reads - base, 2);

    // enable dropped mid-sequence: finish it, then stay idle.
    push_in(32'hBEEF0000);
    wait_ring_read();
    enable = 1'b0;
    wait_drain(500);
    pol = in_polls + out_polls;
    push_in(32'hBEEF0001);
    repeat (60) @(negedge clk);
    check_val("disabled_no_poll", in_polls + out_polls - pol, 0);
    check_val("disabled_word_held", exp_rx.size(), 1);
    @(posedge clk); #1;
    enable = 1'b1;
    wait_drain(500);

    // Wrap-around: QUEUE_SZ+3 words in order.
    for (int k = 0; k < QSZ + 3; k++) push_in($urandom);
    wait_drain(20000);
    check_val("final_in_rd_ptr", mem[0], tb_in_wr);

    check_val("strobe_exclusive", strobe_clash, 0);
    check_val("tx_ready_pulses", tx_pulses, words_sent);
    check_val("rx_queue_empty", exp_rx.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
